// File: rtl/conv_encoder_k.sv
// Rate-1/2 feed-forward convolutional encoder with framed output: FRAME_LEN data symbols followed by
// K-1 zero-tail symbols, registered output that holds under backpressure, out_last on the final tail symbol.
module conv_encoder_k #(
   parameter int             K         = 3,
   parameter logic [K-1:0]   G0        = 3'b111,
   parameter logic [K-1:0]   G1        = 3'b101,
   parameter int             FRAME_LEN = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_bit,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [1:0] out_sym,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       busy
);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_TAIL, S_FLUSH} state_t;

   localparam logic [7:0] FLEN  = 8'(FRAME_LEN);
   localparam logic [2:0] TLAST = 3'(K - 2);

   state_t       state;
   logic [K-2:0] sr;
   logic [7:0]   cnt;
   logic [2:0]   tcnt;
   logic         free;
   logic         accept;
   logic         enc_u;
   logic [K-1:0] word;
   logic [1:0]   sym_next;

   // The output register may be loaded when it is empty or being drained this cycle.
   assign free     = !out_valid || out_ready;
   assign in_ready = !rst && (state == S_IDLE || state == S_DATA) && free;
   assign accept   = in_valid && in_ready;
   assign enc_u    = (state == S_TAIL) ? 1'b0 : in_bit;
   assign word     = {enc_u, sr};
   assign sym_next = {^(G0 & word), ^(G1 & word)};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         sr        <= '0;
         cnt       <= '0;
         tcnt      <= '0;
         out_sym   <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  out_sym   <= sym_next;
                  out_valid <= 1'b1;
                  out_last  <= 1'b0;
                  sr        <= {enc_u, sr[K-2:1]};
                  cnt       <= 8'd1;
                  tcnt      <= '0;
                  busy      <= 1'b1;
                  state     <= (FLEN == 8'd1) ? S_TAIL : S_DATA;
               end else if (free) begin
                  out_valid <= 1'b0;
               end
            end
            S_DATA: begin
               if (accept) begin
                  out_sym   <= sym_next;
                  out_valid <= 1'b1;
                  out_last  <= 1'b0;
                  sr        <= {enc_u, sr[K-2:1]};
                  cnt       <= cnt + 8'd1;
                  if (cnt + 8'd1 == FLEN) begin
                     tcnt  <= '0;
                     state <= S_TAIL;
                  end
               end else if (free) begin
                  out_valid <= 1'b0;
               end
            end
            S_TAIL: begin
               // Zero tail bits are injected internally; no input handshake takes place here.
               if (free) begin
                  out_sym   <= sym_next;
                  out_valid <= 1'b1;
                  sr        <= {enc_u, sr[K-2:1]};
                  tcnt      <= tcnt + 3'd1;
                  if (tcnt == TLAST) begin
                     out_last <= 1'b1;
                     state    <= S_FLUSH;
                  end else begin
                     out_last <= 1'b0;
                  end
               end
            end
            S_FLUSH: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_encoder_k.sv
// Directed bench for conv_encoder_k (K=3, G0=111, G1=101, FRAME_LEN=4): cycle tables for the basic and
// backpressure frames, plus scoreboarded sequences for zero frame, mid-frame reset and back-to-back frames.
module tb_conv_encoder_k;

   logic       clk;
   logic       rst;
   logic       in_bit;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] out_sym;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;
   int stall_cnt = 0;

   logic [2:0] exp_q[$];

   typedef struct {
      logic       v, b, r;
      logic       e_ir, e_ov;
      logic [1:0] e_sym;
      logic       e_last, e_busy;
   } vec_t;

   vec_t tbl [0:15];
   int   n_tbl;

   conv_encoder_k #(.K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_bit    (in_bit),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_sym   (out_sym),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every output handshake is checked against the expected queue.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_sym: got last=%0b sym=%b, queue empty", out_last, out_sym);
         end else begin
            logic [2:0] e;
            e = exp_q.pop_front();
            if ({out_last, out_sym} !== e)
               begin
                  n_err++;
                  $display("FAIL sym_seq: got last=%0b sym=%b, want last=%0b sym=%b",
                           out_last, out_sym, e[2], e[1:0]);
               end
         end
      end
      if (!rst && in_valid && !in_ready) stall_cnt++;
   end

   function automatic vec_t mk(input logic v, b, r, ir, ov, input logic [1:0] s, input logic l, bz);
      vec_t t;
      t.v = v; t.b = b; t.r = r; t.e_ir = ir; t.e_ov = ov; t.e_sym = s; t.e_last = l; t.e_busy = bz;
      return t;
   endfunction

   task automatic push_frame1();
      exp_q.push_back(3'b0_11); exp_q.push_back(3'b0_10); exp_q.push_back(3'b0_00);
      exp_q.push_back(3'b0_01); exp_q.push_back(3'b0_01); exp_q.push_back(3'b1_11);
   endtask

   task automatic run_table(input string name);
      for (int i = 0; i < n_tbl; i++) begin
         @(posedge clk); #1;
         in_valid = tbl[i].v; in_bit = tbl[i].b; out_ready = tbl[i].r;
         @(negedge clk);
         n_vec++;
         if (in_ready !== tbl[i].e_ir || out_valid !== tbl[i].e_ov || busy !== tbl[i].e_busy ||
             out_last !== tbl[i].e_last || (tbl[i].e_ov && out_sym !== tbl[i].e_sym)) begin
            n_err++;
            $display("FAIL %s step %0d: got ir=%0b ov=%0b sym=%b last=%0b busy=%0b, want ir=%0b ov=%0b sym=%b last=%0b busy=%0b",
                     name, i, in_ready, out_valid, out_sym, out_last, busy,
                     tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_sym, tbl[i].e_last, tbl[i].e_busy);
         end
      end
   endtask

   // Call at posedge+1; returns at posedge+1 just after the bit has been accepted.
   task automatic send_bit(input logic b);
      int t;
      in_valid = 1'b1; in_bit = b; t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin @(negedge clk); t++; end
      if (!in_ready) begin
         n_vec++; n_err++;
         $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, want 1", in_ready, t);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_bits(input logic [3:0] bits);
      for (int i = 3; i >= 0; i--) send_bit(bits[i]);
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 60) begin @(negedge clk); t++; end
      repeat (3) @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s_drain: got %0d pending, busy=%0b, want 0 pending, busy=0", name, exp_q.size(), busy);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || out_sym !== 2'b00 || out_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: got ov=%0b sym=%b last=%0b busy=%0b ir=%0b, want all 0",
                  out_valid, out_sym, out_last, busy, in_ready);
      end
      @(posedge clk); #1; rst = 1'b0;

      // Frame 1011 with out_ready high: 11,10,00,01 then tail 01,11(last).
      n_tbl = 8;
      tbl[0] = mk(1,1,1, 1,0,2'b00,0,0);
      tbl[1] = mk(1,0,1, 1,1,2'b11,0,1);
      tbl[2] = mk(1,1,1, 1,1,2'b10,0,1);
      tbl[3] = mk(1,1,1, 1,1,2'b00,0,1);
      tbl[4] = mk(0,0,1, 0,1,2'b01,0,1);
      tbl[5] = mk(0,0,1, 0,1,2'b01,0,1);
      tbl[6] = mk(0,0,1, 0,1,2'b11,1,1);
      tbl[7] = mk(0,0,1, 1,0,2'b00,0,0);
      push_frame1();
      run_table("basic");
      wait_drain("basic");

      // Same frame, out_ready low for 3 cycles while symbol 10 is presented.
      n_tbl = 11;
      tbl[0]  = mk(1,1,1, 1,0,2'b00,0,0);
      tbl[1]  = mk(1,0,1, 1,1,2'b11,0,1);
      tbl[2]  = mk(1,1,0, 0,1,2'b10,0,1);
      tbl[3]  = mk(1,1,0, 0,1,2'b10,0,1);
      tbl[4]  = mk(1,1,0, 0,1,2'b10,0,1);
      tbl[5]  = mk(1,1,1, 1,1,2'b10,0,1);
      tbl[6]  = mk(1,1,1, 1,1,2'b00,0,1);
      tbl[7]  = mk(0,0,1, 0,1,2'b01,0,1);
      tbl[8]  = mk(0,0,1, 0,1,2'b01,0,1);
      tbl[9]  = mk(0,0,1, 0,1,2'b11,1,1);
      tbl[10] = mk(0,0,1, 1,0,2'b00,0,0);
      push_frame1();
      run_table("backpressure");
      wait_drain("backpressure");

      // All-zero frame gives six 00 symbols; the following frame must start from state 0.
      for (int i = 0; i < 5; i++) exp_q.push_back(3'b0_00);
      exp_q.push_back(3'b1_00);
      push_frame1();
      send_bits(4'b0000);
      send_bits(4'b1011);
      wait_drain("zero_frame");

      // Reset after two accepted bits: only 11 has been handed over when reset hits.
      exp_q.push_back(3'b0_11);
      send_bit(1'b1);
      send_bit(1'b0);
      rst = 1'b1;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
         n_err++;
         $display("FAIL midframe_reset: got ov=%0b busy=%0b last=%0b, want 0 0 0", out_valid, busy, out_last);
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL reset_handover: got %0d pending before reset, want 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk); #1; rst = 1'b0;
      push_frame1();
      send_bits(4'b1011);
      wait_drain("after_reset");

      // Back-to-back frames 1011 and 0110 with in_valid held high.
      push_frame1();
      exp_q.push_back(3'b0_00); exp_q.push_back(3'b0_11); exp_q.push_back(3'b0_01);
      exp_q.push_back(3'b0_01); exp_q.push_back(3'b0_11); exp_q.push_back(3'b1_00);
      stall_cnt = 0;
      send_bits(4'b1011);
      send_bits(4'b0110);
      n_vec++;
      if (stall_cnt != 3) begin
         n_err++;
         $display("FAIL b2b_stalls: got %0d in_ready-low cycles, want 3", stall_cnt);
      end
      wait_drain("back_to_back");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
